// File: rtl/lab5_birth_rx.sv
// lab5_birth_rx: decodes active-low 7-segment patterns to BCD and tracks them
// against the birth sequence 2,0,0,1,0,5,1,3, recovering the counter index and period count.
`default_nettype none

module lab5_birth_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       seg_valid,
  input  logic [6:0] seg_data,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       seg_err,
  output logic       locked,
  output logic [2:0] cnt_out,
  output logic       seq_err,
  output logic [7:0] periods
);

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [7:0] PERIODS_MAX = 8'd255;

  state_t     state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic       digit_valid_q, digit_valid_d;
  logic       seg_err_q, seg_err_d;
  logic       seq_err_q, seq_err_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] periods_q, periods_d;

  logic       dec_legal;
  logic [3:0] dec_digit;
  logic       dec_anchor;
  logic [2:0] anchor_idx;
  logic [2:0] next_idx;
  logic [3:0] exp_digit;

  // Digit expected at each counter index of the birth sequence.
  function automatic logic [3:0] seq_digit(input logic [2:0] idx);
    case (idx)
      3'd0:    seq_digit = 4'd2;
      3'd1:    seq_digit = 4'd0;
      3'd2:    seq_digit = 4'd0;
      3'd3:    seq_digit = 4'd1;
      3'd4:    seq_digit = 4'd0;
      3'd5:    seq_digit = 4'd5;
      3'd6:    seq_digit = 4'd1;
      default: seq_digit = 4'd3;
    endcase
  endfunction

  always_comb begin
    dec_legal = 1'b1;
    dec_digit = 4'd0;
    case (seg_data)
      7'h40:   dec_digit = 4'd0;
      7'h79:   dec_digit = 4'd1;
      7'h24:   dec_digit = 4'd2;
      7'h30:   dec_digit = 4'd3;
      7'h19:   dec_digit = 4'd4;
      7'h12:   dec_digit = 4'd5;
      7'h02:   dec_digit = 4'd6;
      7'h78:   dec_digit = 4'd7;
      7'h00:   dec_digit = 4'd8;
      7'h10:   dec_digit = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  // Anchors appear at exactly one index, so they pin the counter on sight.
  always_comb begin
    dec_anchor = 1'b0;
    anchor_idx = 3'd0;
    case (dec_digit)
      4'd2: begin dec_anchor = 1'b1; anchor_idx = 3'd0; end
      4'd5: begin dec_anchor = 1'b1; anchor_idx = 3'd5; end
      4'd3: begin dec_anchor = 1'b1; anchor_idx = 3'd7; end
      default: ;
    endcase
  end

  assign next_idx  = cnt_q + 3'd1;
  assign exp_digit = seq_digit(next_idx);

  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    seg_err_d     = 1'b0;
    seq_err_d     = 1'b0;
    cnt_d         = cnt_q;
    periods_d     = periods_q;

    if (seg_valid) begin
      if (!dec_legal) begin
        seg_err_d = 1'b1;
        state_d   = HUNT;
      end else begin
        digit_d       = dec_digit;
        digit_valid_d = 1'b1;
        case (state_q)
          HUNT: begin
            if (dec_anchor) begin
              state_d = TRACK;
              cnt_d   = anchor_idx;
            end
          end
          TRACK: begin
            if (dec_digit == exp_digit) begin
              cnt_d = next_idx;
              if (cnt_q == 3'd7 && periods_q != PERIODS_MAX) begin
                periods_d = periods_q + 8'd1;
              end
            end else begin
              seq_err_d = 1'b1;
              // An anchor relocks in place; anything else drops back to hunting.
              if (dec_anchor) begin
                cnt_d = anchor_idx;
              end else begin
                state_d = HUNT;
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      cnt_q         <= 3'd0;
      periods_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      seg_err_q     <= seg_err_d;
      seq_err_q     <= seq_err_d;
      cnt_q         <= cnt_d;
      periods_q     <= periods_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign seg_err     = seg_err_q;
  assign locked      = (state_q == TRACK);
  assign cnt_out     = cnt_q;
  assign seq_err     = seq_err_q;
  assign periods     = periods_q;

endmodule

`default_nettype wire

// File: doc/lab5_birth_rx.md
# lab5_birth_rx

Receive-side companion to the lab5 birth-digit display encoder. Accepts a stream of active-low 7-segment patterns, decodes each to a BCD digit, flags illegal patterns, and tracks the digits against the fixed 8-entry birth sequence 2,0,0,1,0,5,1,3. It recovers the 3-bit counter index that produced each digit and counts completed sequence periods. It sits between a segment-pattern source (display tap or test harness) and lab-level checking logic.

## Interface
- No parameters; widths and sequence table are fixed.
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- seg_valid  in  1  strobe: seg_data is sampled this cycle
- seg_data  in  7  pattern, active-low, bit6=g … bit0=a
- digit  out  4  last decoded BCD digit
- digit_valid  out  1  one-cycle pulse: digit updated
- seg_err  out  1  one-cycle pulse: illegal pattern received
- locked  out  1  tracker synchronised to sequence
- cnt_out  out  3  recovered counter index of last accepted digit (valid when locked)
- seq_err  out  1  one-cycle pulse: in-sequence mismatch while locked
- periods  out  8  completed sequence periods, saturating at 255

## Operation
- Decode table (hex pattern -> digit): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9. Any other pattern is illegal.
- Sequence table, index->digit: 0->2, 1->0, 2->0, 3->1, 4->0, 5->5, 6->1, 7->3.
- Anchor digits (occur at one index only): 2 (idx 0), 5 (idx 5), 3 (idx 7).
- States: HUNT, TRACK. Reset state HUNT.
- Per seg_valid cycle:
  - Illegal pattern: seg_err=1, digit_valid=0, digit unchanged; go HUNT, locked=0; cnt_out and periods unchanged.
  - Legal pattern: digit<=decoded, digit_valid=1, then the tracker step below.
- Tracker, HUNT: anchor digit -> TRACK, cnt_out<=anchor index, locked=1. Non-anchor digit -> stay HUNT.
- Tracker, TRACK: the expected digit is table[(cnt_out+1) mod 8].
  - Match: cnt_out<=cnt_out+1, wrapping 7->0. On wrap 7->0, periods<=periods+1, saturating at 255.
  - Mismatch: seq_err=1. If the received digit is an anchor, stay TRACK with cnt_out<=its index (immediate relock, no period increment). Otherwise go HUNT, locked=0.
- seg_valid=0: no state change, all pulses 0.
- periods is cleared only by rst. It is not cleared by loss of lock.

## Timing
- All outputs registered. Response appears the cycle after the sampling edge (1-cycle latency).
- Back-to-back seg_valid every cycle is supported at full rate with no stall.
- Pulses (digit_valid, seg_err, seq_err) are high for exactly one cycle per sampled input.
- seg_err and seq_err are never high in the same cycle. digit_valid and seg_err are mutually exclusive.
- Reset values: digit=0, digit_valid=0, seg_err=0, locked=0, cnt_out=0, seq_err=0, periods=0, state HUNT.
- rst asserted mid-stream clears everything immediately, regardless of clk. The first seg_valid after release is processed normally.

## Test plan
- Decode sweep: apply each of the 10 legal patterns, then 7F and 7E -> correct digit with digit_valid for the legal ones; seg_err for 7F/7E with digit held.
- Lock from HUNT: send 0,1,0 then 2 -> locked stays 0 through the first three, then locked=1, cnt_out=0. Continue 0,0,1,0,5,1,3 -> cnt_out steps 1..7, no seq_err.
- Wrap and periods: after lock, send 3 full periods back-to-back at one per cycle -> periods=3 and cnt_out=7 after the final 3. Next 2 -> cnt_out=0 and periods=4.
- Mismatch: locked at cnt_out=3, send 9 -> seq_err pulse, locked=0. Locked at cnt_out=3, send 5 -> seq_err pulse, locked stays 1, cnt_out=5.
- Illegal mid-track: locked at cnt_out=4, send pattern 7F -> seg_err pulse, locked=0, cnt_out stays 4, periods unchanged.
- Reset mid-operation: with periods=2 and locked, assert rst between clock edges -> all outputs 0 immediately. After release, sending 3 -> locked=1, cnt_out=7.
